// File: rtl/mem_slot_scheduler_if.sv
// Extra-slot client handshake and shared memory bus of the slot scheduler.
// The scheduler takes the slave side; the memory/client fabric takes the master side.
interface mem_slot_scheduler_if #(
  parameter int NUM_EXT = 4,
  parameter int ADDR_W  = 22
);
  logic [NUM_EXT-1:0]        ext_req;
  logic [NUM_EXT-1:0]        ext_we;
  logic [NUM_EXT*ADDR_W-1:0] ext_addr;
  logic [NUM_EXT-1:0]        ext_ack;
  logic [NUM_EXT-1:0]        ext_done;
  logic [NUM_EXT-1:0]        ext_starve;
  logic [ADDR_W-1:0]         memoryAddr;
  logic                      _memoryUDS;
  logic                      _memoryLDS;
  logic                      _ramOE;
  logic                      _ramWE;
  logic                      _romOE;

  modport master (
    output ext_req, ext_we, ext_addr,
    input  ext_ack, ext_done, ext_starve,
    input  memoryAddr, _memoryUDS, _memoryLDS, _ramOE, _ramWE, _romOE
  );

  modport slave (
    input  ext_req, ext_we, ext_addr,
    output ext_ack, ext_done, ext_starve,
    output memoryAddr, _memoryUDS, _memoryLDS, _ramOE, _ramWE, _romOE
  );
endinterface

// File: rtl/mem_slot_scheduler.sv
// Four-phase bus slot rotation (video, cpu, extra, cpu) with an arbitrated extra
// slot shared by NUM_EXT request/ack clients, plus the RAM/ROM address and strobe mux.
module mem_slot_scheduler #(
  parameter int                        NUM_EXT      = 4,
  parameter int                        ADDR_W       = 22,
  parameter logic [NUM_EXT*ADDR_W-1:0] EXT_BASE     = {(NUM_EXT*ADDR_W){1'b0}},
  parameter int                        ARB_MODE     = 0,
  parameter int                        STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              _reset,
  output logic              clk8_en_p,
  output logic              clk8_en_n,
  output logic              clk16_en_p,
  output logic              memoryLatch,
  output logic [1:0]        busCycle,
  output logic              videoBusControl,
  output logic              cpuBusControl,
  input  logic              video_active,
  input  logic [ADDR_W-1:0] videoAddr,
  input  logic [ADDR_W-1:0] cpuAddr,
  input  logic              cpu_sel_ram,
  input  logic              cpu_sel_rom,
  input  logic              _cpuRW,
  input  logic              _cpuUDS,
  input  logic              _cpuLDS,
  mem_slot_scheduler_if.slave bus
);
  localparam int IDX_W = (NUM_EXT > 1) ? $clog2(NUM_EXT) : 1;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STARVE_LIMIT);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_EXT - 1);

  logic [1:0]         busPhase;
  logic               grantValid;
  logic [IDX_W-1:0]   grantIdx;
  logic [IDX_W-1:0]   lastGrant;
  logic [CNT_W-1:0]   starveCnt [NUM_EXT];
  logic [NUM_EXT-1:0] starveFlag;
  logic               arbEdge;
  logic               pickValid;
  logic [IDX_W-1:0]   pickIdx;
  logic [IDX_W-1:0]   cand;
  logic [ADDR_W-1:0]  extAddrArr [NUM_EXT];
  logic [ADDR_W-1:0]  extBaseArr [NUM_EXT];
  logic [NUM_EXT-1:0] extAck;
  logic               extActive;
  logic               extWrite;
  logic               cpuSlot;
  logic               ramOeLow;
  logic               ramWeLow;
  logic               romOeLow;

  for (genvar i = 0; i < NUM_EXT; i++) begin : gUnpack
    assign extAddrArr[i] = bus.ext_addr[i*ADDR_W +: ADDR_W];
    assign extBaseArr[i] = EXT_BASE[i*ADDR_W +: ADDR_W];
  end

  assign arbEdge         = (busPhase == 2'd3) && (busCycle == 2'd1);
  assign clk8_en_p       = (busPhase == 2'd3);
  assign clk8_en_n       = (busPhase == 2'd1);
  assign clk16_en_p      = !busPhase[0];
  assign memoryLatch     = (busPhase == 2'd3);
  assign videoBusControl = (busCycle == 2'd0);
  assign cpuBusControl   = busCycle[0];

  // Winner search: round robin starts just after lastGrant, fixed priority at index 0.
  always_comb begin
    pickValid = 1'b0;
    pickIdx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_EXT; k++) begin
      if (ARB_MODE == 0) begin
        cand = IDX_W'((int'(lastGrant) + 1 + k) % NUM_EXT);
      end else begin
        cand = IDX_W'(k);
      end
      if (!pickValid && bus.ext_req[cand]) begin
        pickValid = 1'b1;
        pickIdx   = cand;
      end else begin
        pickValid = pickValid;
      end
    end
  end

  // Slot rotation and grant latch on the edge entering the extra slot.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      busPhase   <= 2'd0;
      busCycle   <= 2'd0;
      grantValid <= 1'b0;
      grantIdx   <= '0;
      lastGrant  <= LAST_INIT;
    end else begin
      busPhase <= busPhase + 2'd1;
      if (busPhase == 2'd3) busCycle <= busCycle + 2'd1;
      if (arbEdge) begin
        grantValid <= pickValid;
        grantIdx   <= pickIdx;
        if (pickValid) lastGrant <= pickIdx;
      end
    end
  end

  // Starve bookkeeping: losers count up (saturating), the winner is cleared.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      starveFlag <= '0;
      for (int i = 0; i < NUM_EXT; i++) starveCnt[i] <= '0;
    end else if (arbEdge) begin
      for (int i = 0; i < NUM_EXT; i++) begin
        if (pickValid && (pickIdx == IDX_W'(i))) begin
          starveCnt[i]  <= '0;
          starveFlag[i] <= 1'b0;
        end else if (bus.ext_req[i]) begin
          if (starveCnt[i] < CNT_MAX) starveCnt[i] <= starveCnt[i] + CNT_W'(1);
          if (starveCnt[i] >= CNT_MAX - CNT_W'(1)) starveFlag[i] <= 1'b1;
        end
      end
    end
  end

  // Address, strobes and handshake; strobes are forced inactive while in reset.
  always_comb begin
    extActive = (busCycle == 2'd2) && grantValid;
    extWrite  = bus.ext_we[grantIdx];
    cpuSlot   = busCycle[0];
    extAck    = '0;
    if (extActive) begin
      extAck[grantIdx] = 1'b1;
    end else begin
      extAck = '0;
    end
    if (extActive) begin
      bus.memoryAddr = extAddrArr[grantIdx] + extBaseArr[grantIdx];
    end else if (videoBusControl) begin
      bus.memoryAddr = videoAddr;
    end else begin
      bus.memoryAddr = cpuAddr;
    end
    ramOeLow = (videoBusControl && video_active) || (extActive && !extWrite) ||
               (cpuSlot && cpu_sel_ram && _cpuRW);
    ramWeLow = (cpuSlot && cpu_sel_ram && !_cpuRW && (!_cpuUDS || !_cpuLDS)) ||
               (extActive && extWrite);
    romOeLow = cpuSlot && cpu_sel_rom && _cpuRW;
    bus._ramOE = !(_reset && ramOeLow);
    bus._ramWE = !(_reset && ramWeLow);
    bus._romOE = !(_reset && romOeLow);
    if (cpuSlot) begin
      bus._memoryUDS = _cpuUDS;
      bus._memoryLDS = _cpuLDS;
    end else begin
      bus._memoryUDS = 1'b0;
      bus._memoryLDS = 1'b0;
    end
  end

  assign bus.ext_ack    = extAck;
  assign bus.ext_done   = extAck & {NUM_EXT{busPhase == 2'd3}};
  assign bus.ext_starve = starveFlag;
endmodule

// File: tb/tb_mem_slot_scheduler.sv
// Directed bench: one round-robin and one fixed-priority scheduler driven by the
// same stimulus; every value is checked against hand-computed constants.
module tb_mem_slot_scheduler;
  localparam int NUM_EXT = 4;
  localparam int ADDR_W  = 22;
  localparam logic [NUM_EXT*ADDR_W-1:0] BASE = {22'h000000, 22'h3FFFF0, 22'h200000, 22'h000000};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      _reset;
  logic                      video_active;
  logic [ADDR_W-1:0]         videoAddr;
  logic [ADDR_W-1:0]         cpuAddr;
  logic                      cpu_sel_ram;
  logic                      cpu_sel_rom;
  logic                      _cpuRW;
  logic                      _cpuUDS;
  logic                      _cpuLDS;
  logic [NUM_EXT-1:0]        extReq;
  logic [NUM_EXT-1:0]        extWe;
  logic [NUM_EXT*ADDR_W-1:0] extAddr;

  logic       clk8p, clk8n, clk16p, memLatch, videoCtl, cpuCtl;
  logic [1:0] busCycle;
  logic       fpClk8p, fpClk8n, fpClk16p, fpMemLatch, fpVideoCtl, fpCpuCtl;
  logic [1:0] fpBusCycle;

  mem_slot_scheduler_if #(.NUM_EXT(NUM_EXT), .ADDR_W(ADDR_W)) busRr();
  mem_slot_scheduler_if #(.NUM_EXT(NUM_EXT), .ADDR_W(ADDR_W)) busFp();

  assign busRr.ext_req  = extReq;
  assign busRr.ext_we   = extWe;
  assign busRr.ext_addr = extAddr;
  assign busFp.ext_req  = extReq;
  assign busFp.ext_we   = extWe;
  assign busFp.ext_addr = extAddr;

  mem_slot_scheduler #(.NUM_EXT(NUM_EXT), .ADDR_W(ADDR_W), .EXT_BASE(BASE),
                       .ARB_MODE(0), .STARVE_LIMIT(8)) dutRr (
    .clk(clk), ._reset(_reset), .clk8_en_p(clk8p), .clk8_en_n(clk8n),
    .clk16_en_p(clk16p), .memoryLatch(memLatch), .busCycle(busCycle),
    .videoBusControl(videoCtl), .cpuBusControl(cpuCtl), .video_active(video_active),
    .videoAddr(videoAddr), .cpuAddr(cpuAddr), .cpu_sel_ram(cpu_sel_ram),
    .cpu_sel_rom(cpu_sel_rom), ._cpuRW(_cpuRW), ._cpuUDS(_cpuUDS), ._cpuLDS(_cpuLDS),
    .bus(busRr.slave)
  );

  mem_slot_scheduler #(.NUM_EXT(NUM_EXT), .ADDR_W(ADDR_W), .EXT_BASE(BASE),
                       .ARB_MODE(1), .STARVE_LIMIT(8)) dutFp (
    .clk(clk), ._reset(_reset), .clk8_en_p(fpClk8p), .clk8_en_n(fpClk8n),
    .clk16_en_p(fpClk16p), .memoryLatch(fpMemLatch), .busCycle(fpBusCycle),
    .videoBusControl(fpVideoCtl), .cpuBusControl(fpCpuCtl), .video_active(video_active),
    .videoAddr(videoAddr), .cpuAddr(cpuAddr), .cpu_sel_ram(cpu_sel_ram),
    .cpu_sel_rom(cpu_sel_rom), ._cpuRW(_cpuRW), ._cpuUDS(_cpuUDS), ._cpuLDS(_cpuLDS),
    .bus(busFp.slave)
  );

  int assertCnt = 0;
  int failCnt   = 0;
  int clkNo     = 0;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCnt++;
    if (obs !== exp) begin
      failCnt++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Clk n is the cycle after the n-th rising edge following reset release.
  task automatic gotoClk(input int t);
    while (clkNo < t) begin
      @(negedge clk);
      clkNo++;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    _reset = 1'b0;
    repeat (2) @(negedge clk);
    _reset = 1'b1;
    clkNo = 0;
  endtask

  logic [ADDR_W-1:0] rrAddrExp [4];
  logic [3:0]        oneHot;

  initial begin
    rrAddrExp = '{22'h000040, 22'h200010, 22'h000010, 22'h000123};
    _reset = 1'b0; video_active = 1'b1; videoAddr = 22'h0; cpuAddr = 22'h0;
    cpu_sel_ram = 1'b0; cpu_sel_rom = 1'b0; _cpuRW = 1'b1; _cpuUDS = 1'b1; _cpuLDS = 1'b1;
    extReq = 4'b0000; extWe = 4'b0000; extAddr = '0;

    // Reset state (video_active high must not pull _ramOE low while in reset).
    @(negedge clk);
    checkEq("rst_busCycle", 32'(busCycle), 32'd0);
    checkEq("rst_ack", 32'(busRr.ext_ack), 32'd0);
    checkEq("rst_done", 32'(busRr.ext_done), 32'd0);
    checkEq("rst_starve", 32'(busFp.ext_starve), 32'd0);
    checkEq("rst_ramOE", 32'(busRr._ramOE), 32'd1);
    checkEq("rst_ramWE", 32'(busRr._ramWE), 32'd1);
    checkEq("rst_romOE", 32'(busRr._romOE), 32'd1);
    video_active = 1'b0;
    @(negedge clk);
    _reset = 1'b1;
    clkNo = 0;

    // Idle rotation: enables, slot index and idle extra slot.
    for (int k = 0; k < 16; k++) begin
      gotoClk(k);
      checkEq($sformatf("clk8p@%0d", k), 32'(clk8p), 32'((k % 4) == 3));
      checkEq($sformatf("clk8n@%0d", k), 32'(clk8n), 32'((k % 4) == 1));
      checkEq($sformatf("clk16p@%0d", k), 32'(clk16p), 32'((k % 2) == 0));
      checkEq($sformatf("latch@%0d", k), 32'(memLatch), 32'((k % 4) == 3));
      checkEq($sformatf("busCycle@%0d", k), 32'(busCycle), 32'((k / 4) % 4));
      checkEq($sformatf("fpBusCycle@%0d", k), 32'(fpBusCycle), 32'((k / 4) % 4));
      checkEq($sformatf("videoCtl@%0d", k), 32'(videoCtl), 32'(((k / 4) % 4) == 0));
      checkEq($sformatf("cpuCtl@%0d", k), 32'(cpuCtl), 32'(((k / 4) % 4) % 2 == 1));
      checkEq($sformatf("idleAck@%0d", k), 32'(busRr.ext_ack), 32'd0);
      checkEq($sformatf("idleRamOE@%0d", k), 32'(busRr._ramOE), 32'd1);
      checkEq($sformatf("idleRamWE@%0d", k), 32'(busRr._ramWE), 32'd1);
    end

    // Single read client 1 with base 0x200000.
    doReset();
    extReq = 4'b0010;
    extAddr = {22'h0, 22'h0, 22'h000010, 22'h0};
    for (int k = 7; k <= 12; k++) begin
      gotoClk(k);
      checkEq($sformatf("c1AckRr@%0d", k), 32'(busRr.ext_ack), ((k >= 8) && (k <= 11)) ? 32'h2 : 32'h0);
      checkEq($sformatf("c1AckFp@%0d", k), 32'(busFp.ext_ack), ((k >= 8) && (k <= 11)) ? 32'h2 : 32'h0);
      checkEq($sformatf("c1Done@%0d", k), 32'(busRr.ext_done), (k == 11) ? 32'h2 : 32'h0);
      if ((k >= 8) && (k <= 11)) begin
        checkEq($sformatf("c1Addr@%0d", k), 32'(busRr.memoryAddr), 32'h200010);
        checkEq($sformatf("c1RamOE@%0d", k), 32'(busRr._ramOE), 32'd0);
        checkEq($sformatf("c1RamWE@%0d", k), 32'(busRr._ramWE), 32'd1);
      end
    end
    extReq = 4'b0000;

    // All four request: round robin 0,1,2,3,0; fixed priority always 0.
    doReset();
    extReq = 4'b1111;
    extAddr = {22'h000123, 22'h000020, 22'h000010, 22'h000040};
    for (int n = 0; n < 5; n++) begin
      gotoClk(16 * n + 9);
      oneHot = 4'b0001 << (n % 4);
      checkEq($sformatf("rrAck#%0d", n), 32'(busRr.ext_ack), 32'(oneHot));
      checkEq($sformatf("rrAddr#%0d", n), 32'(busRr.memoryAddr), 32'(rrAddrExp[n % 4]));
      checkEq($sformatf("fpAck#%0d", n), 32'(busFp.ext_ack), 32'h1);
    end
    extReq = 4'b0000;

    // Starvation under fixed priority.
    doReset();
    extReq = 4'b0011;
    gotoClk(105);
    checkEq("fpAck105", 32'(busFp.ext_ack), 32'h1);
    checkEq("starve7lost", 32'(busFp.ext_starve), 32'h0);
    gotoClk(121);
    checkEq("starve8lost", 32'(busFp.ext_starve), 32'h2);
    checkEq("rrNoStarve", 32'(busRr.ext_starve), 32'h0);
    gotoClk(122);
    extReq = 4'b0010;
    gotoClk(133);
    checkEq("starveSticky", 32'(busFp.ext_starve), 32'h2);
    gotoClk(137);
    checkEq("starveGrant", 32'(busFp.ext_ack), 32'h2);
    checkEq("starveClear", 32'(busFp.ext_starve), 32'h0);
    extReq = 4'b0000;

    // Write client 2 with wrapping base.
    doReset();
    extReq = 4'b0100;
    extWe = 4'b0100;
    extAddr = {22'h0, 22'h000020, 22'h0, 22'h0};
    gotoClk(9);
    checkEq("wrAckRr", 32'(busRr.ext_ack), 32'h4);
    checkEq("wrAckFp", 32'(busFp.ext_ack), 32'h4);
    checkEq("wrAddr", 32'(busRr.memoryAddr), 32'h000010);
    checkEq("wrRamWE", 32'(busRr._ramWE), 32'd0);
    checkEq("wrRamOE", 32'(busRr._ramOE), 32'd1);
    checkEq("wrUDS", 32'(busRr._memoryUDS), 32'd0);
    checkEq("wrLDS", 32'(busRr._memoryLDS), 32'd0);
    gotoClk(11);
    checkEq("wrDone", 32'(busRr.ext_done), 32'h4);
    extReq = 4'b0000;
    extWe = 4'b0000;

    // Video read, CPU byte write, idle extra slot, CPU ROM read.
    doReset();
    video_active = 1'b1; videoAddr = 22'h012345; cpuAddr = 22'h00ABCD;
    cpu_sel_ram = 1'b1; _cpuRW = 1'b0; _cpuUDS = 1'b0; _cpuLDS = 1'b1;
    gotoClk(1);
    checkEq("vidAddr", 32'(busRr.memoryAddr), 32'h012345);
    checkEq("vidRamOE", 32'(busRr._ramOE), 32'd0);
    checkEq("vidRamWE", 32'(busRr._ramWE), 32'd1);
    gotoClk(5);
    checkEq("cpuAddr", 32'(busRr.memoryAddr), 32'h00ABCD);
    checkEq("cpuRamWE", 32'(busRr._ramWE), 32'd0);
    checkEq("cpuRamOE", 32'(busRr._ramOE), 32'd1);
    checkEq("cpuUDS", 32'(busRr._memoryUDS), 32'd0);
    checkEq("cpuLDS", 32'(busRr._memoryLDS), 32'd1);
    gotoClk(9);
    checkEq("idleXAddr", 32'(busRr.memoryAddr), 32'h00ABCD);
    checkEq("idleXRamOE", 32'(busRr._ramOE), 32'd1);
    checkEq("idleXRamWE", 32'(busRr._ramWE), 32'd1);
    checkEq("idleXUDS", 32'(busRr._memoryUDS), 32'd0);
    gotoClk(12);
    cpu_sel_ram = 1'b0; cpu_sel_rom = 1'b1; _cpuRW = 1'b1;
    gotoClk(13);
    checkEq("romOE", 32'(busRr._romOE), 32'd0);
    checkEq("romRamOE", 32'(busRr._ramOE), 32'd1);
    video_active = 1'b0; cpu_sel_rom = 1'b0; _cpuUDS = 1'b1; _cpuLDS = 1'b1;

    // Reset in the middle of a granted extra slot.
    doReset();
    extReq = 4'b0001;
    gotoClk(9);
    checkEq("preRstAck", 32'(busRr.ext_ack), 32'h1);
    #2 _reset = 1'b0;
    #1;
    checkEq("midRstAck", 32'(busRr.ext_ack), 32'h0);
    checkEq("midRstDone", 32'(busRr.ext_done), 32'h0);
    checkEq("midRstRamOE", 32'(busRr._ramOE), 32'd1);
    checkEq("midRstCycle", 32'(busCycle), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkEq($sformatf("rstNoDone#%0d", k), 32'(busRr.ext_done), 32'h0);
    end
    extReq = 4'b1111;
    _reset = 1'b1;
    clkNo = 0;
    gotoClk(9);
    checkEq("postRstFirst", 32'(busRr.ext_ack), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end
endmodule
